// File: rtl/pipelined_cla_adder.sv
// ============================================================================
// pipelined_cla_adder
// ----------------------------------------------------------------------------
// Three-stage pipelined carry-lookahead adder/subtractor with a valid/ready
// stream interface on both sides.
//   S1: latch operands, invert B for subtract, form per-bit propagate/generate
//   S2: group propagate/generate and the group carry-in chain
//   S3: in-group lookahead carries, sum, carry out and signed overflow
//
// Parameters
//   WIDTH  operand/result width (>= 4, multiple of GROUP)
//   GROUP  lookahead group size in bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (drops every in-flight beat)
//   in_valid   operand beat valid
//   in_ready   block accepts the beat this cycle
//   in_a       operand A
//   in_b       operand B
//   in_cin     carry in (ignored when in_sub = 1)
//   in_sub     1 = A - B, 0 = A + B + cin
//   in_sat     saturate on overflow (only with CLA_SAT_EN)
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_sum    result
//   out_cout   carry out of the MSB (subtract: 1 = no borrow)
//   out_ovf    signed two's-complement overflow
//
// Optional feature macro: CLA_SAT_EN
//   Adds in_sat. A beat with in_sat = 1 that overflows returns the most
//   positive or most negative value, chosen by the sign of operand A.
//   Without the macro the sum always wraps modulo 2^WIDTH.
// ============================================================================
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
`ifdef CLA_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NG = WIDTH / GROUP;

    // Carry into position n of a group, written as the flat lookahead sum
    // g[n-1] | p[n-1]g[n-2] | ... | p[n-1]..p[0]cin. n = GROUP gives the
    // group generate (with cin = 0) or the group carry out.
    function automatic logic group_carry(input logic [GROUP-1:0] p,
                                         input logic [GROUP-1:0] g,
                                         input logic             cin,
                                         input int               n);
        logic c;
        logic prod;
        c    = 1'b0;
        prod = 1'b1;
        for (int k = GROUP - 1; k >= 0; k--) begin
            if (k < n) begin
                c    = c | (prod & g[k]);
                prod = prod & p[k];
            end
        end
        return c | (prod & cin);
    endfunction

    logic v1, v2, v3;
    logic ready1, ready2, ready3;

    // A stage may load whenever it is empty or its contents move on, so
    // bubbles collapse even while the output is stalled.
    assign ready3    = !v3 | out_ready;
    assign ready2    = !v2 | ready3;
    assign ready1    = !v1 | ready2;
    assign in_ready  = ready1;
    assign out_valid = v3;

    // ------------------------------------------------------------------
    // S1: operand capture. Subtract is A + ~B + 1.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p1, g1;
    logic             c0_1;
`ifdef CLA_SAT_EN
    logic             sat1, amsb1;
`endif

    assign b_eff = in_sub ? ~in_b : in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            p1    <= '0;
            g1    <= '0;
            c0_1  <= 1'b0;
`ifdef CLA_SAT_EN
            sat1  <= 1'b0;
            amsb1 <= 1'b0;
`endif
        end else if (ready1) begin
            v1 <= in_valid;
            if (in_valid) begin
                p1    <= in_a ^ b_eff;
                g1    <= in_a & b_eff;
                c0_1  <= in_sub | in_cin;
`ifdef CLA_SAT_EN
                sat1  <= in_sat;
                amsb1 <= in_a[WIDTH-1];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: group lookahead. Each group's carry-in comes from the previous
    // group's GG | GP & carry.
    // ------------------------------------------------------------------
    logic [NG-1:0] gc_next;

    always_comb begin
        logic c;
        logic gp, gg;
        gc_next = '0;
        c       = c0_1;
        for (int gi = 0; gi < NG; gi++) begin
            gc_next[gi] = c;
            gp = &p1[gi*GROUP +: GROUP];
            gg = group_carry(p1[gi*GROUP +: GROUP], g1[gi*GROUP +: GROUP], 1'b0, GROUP);
            c  = gg | (gp & c);
        end
    end

    logic [WIDTH-1:0] p2, g2;
    logic [NG-1:0]    gc2;
`ifdef CLA_SAT_EN
    logic             sat2, amsb2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            p2    <= '0;
            g2    <= '0;
            gc2   <= '0;
`ifdef CLA_SAT_EN
            sat2  <= 1'b0;
            amsb2 <= 1'b0;
`endif
        end else if (ready2) begin
            v2 <= v1;
            if (v1) begin
                p2    <= p1;
                g2    <= g1;
                gc2   <= gc_next;
`ifdef CLA_SAT_EN
                sat2  <= sat1;
                amsb2 <= amsb1;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: every bit carry from its group carry-in; c_all is WIDTH+1 wide
    // so the MSB carry out is kept for cout and overflow.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   c_all;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c, ovf_c;

    always_comb begin
        c_all = '0;
        for (int gi = 0; gi < NG; gi++) begin
            for (int j = 0; j < GROUP; j++) begin
                c_all[gi*GROUP + j] = group_carry(p2[gi*GROUP +: GROUP],
                                                  g2[gi*GROUP +: GROUP], gc2[gi], j);
            end
        end
        c_all[WIDTH] = group_carry(p2[WIDTH-GROUP +: GROUP], g2[WIDTH-GROUP +: GROUP],
                                   gc2[NG-1], GROUP);
        cout_c = c_all[WIDTH];
        ovf_c  = c_all[WIDTH-1] ^ c_all[WIDTH];
        sum_c  = p2 ^ c_all[WIDTH-1:0];
`ifdef CLA_SAT_EN
        // Clamp toward the sign of A; cout and ovf still report the raw result.
        if (sat2 && ovf_c) begin
            sum_c = amsb2 ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (ready3) begin
            v3 <= v2;
            if (v2) begin
                out_sum  <= sum_c;
                out_cout <= cout_c;
                out_ovf  <= ovf_c;
            end
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
- Computes per-bit propagate/generate, then group and carry lookahead, then sum, across three register stages.
- Arithmetic core for datapath blocks that need a WIDTH-bit add/sub with carry, overflow and flow control.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 4 and a multiple of GROUP.
- GROUP, 4, lookahead group size in bits; carry ripples between groups through the group P/G chain.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts the beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry in; ignored when in_sub=1
- in_sub  input  1  1 = A−B, 0 = A+B+cin
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: asynchronous, active-low, on rst_n low. Clears all stage valid flags. Data registers are don't-care.
  - During reset: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, in_ready=1.
- Stage S1 (input register): captures in_a and b' = in_sub ? ~in_b : in_b. Computes c0 = in_sub ? 1 : in_cin. Registers per-bit p = a^b', g = a&b', plus a, b' and c0.
- Stage S2 (lookahead): per group, GP = AND of p over the group, GG = the standard lookahead OR-of-ANDs. Group carries are c_{k+1} = GG_k | GP_k & c_k from c0. Registers bit p, g, the group carry-ins, and the operand MSBs.
- Stage S3 (sum): bit carries inside each group come from the group carry-in via lookahead. sum_i = p_i ^ c_i. cout = carry out of bit WIDTH−1. ovf = c_{WIDTH−1} ^ cout. Registered to out_*.
- Latency: 3 cycles from accepted input to out_valid with no stall. Throughput: 1 beat/cycle.
- Handshake:
  - A beat transfers when valid & ready on that cycle.
  - Per-stage advance: ready_k = !v_k | ready_{k+1}, with ready_4 = out_ready.
  - in_ready = ready_1.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
- out_valid stays high and out_sum/out_cout/out_ovf stay stable until out_ready=1. Output must not change while stalled.
- in_valid without in_ready: the beat is not captured, and the upstream source holds it.
- Simultaneous accept and emit when full: allowed; the pipeline shifts as a whole.
- Reset mid-operation: all in-flight beats are discarded; no beat emitted after rst_n deasserts until a new input is accepted.
- Carry/width: internal carries are WIDTH+1 wide; no truncation before cout. Subtract of equal operands gives sum=0, cout=1.

Optional Feature:
- Macro CLA_SAT_EN. When defined, adds an input port in_sat (1 bit), carried with its beat through all three stages.
- With in_sat=1 and ovf=1, out_sum saturates:
  - 0x7FF..F when operand A MSB is 0 (positive overflow);
  - 0x800..0 when operand A MSB is 1.
- out_ovf still reports 1, and out_cout is unchanged.
- Without CLA_SAT_EN: no in_sat port and the sum always wraps modulo 2^WIDTH.

Test Plan:
- WIDTH=16, add 0xFFFF+0x0001, cin=0 → after 3 cycles out_sum=0x0000, cout=1, ovf=0.
- Add 0x7FFF+0x0001 → out_sum=0x8000, cout=0, ovf=1. With CLA_SAT_EN and in_sat=1 → out_sum=0x7FFF, ovf=1.
- Subtract 0x0005−0x0007 → out_sum=0xFFFE, cout=0, ovf=0. Subtract 0x1234−0x1234 → 0x0000, cout=1.
- Back-to-back 8 beats (i+0x0100, i=0..7) with out_ready low for cycles 4–7:
  - Results are in order, with no loss or duplication.
  - out_sum is stable while stalled.
  - in_ready falls only once all 3 stages are full.
- Pulse rst_n low for 1 cycle with 2 beats in flight → out_valid=0 immediately. No stale result afterwards, and the next accepted beat appears 3 cycles later.
- Random 10k beats, WIDTH=32, GROUP=8, random in_valid/out_ready → every result matches the reference model (a ± b + cin), including cout and ovf.
